bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with hold-time preemption.
// Grants are registered and one-hot; a master holding the bus for MAX_HOLD
// cycles is forced off when another master is waiting.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       preempt
);

  localparam logic [7:0] CntMax = 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] others;
  logic [1:0] win_all, win_oth, new_win;
  logic       take_new;

  // First requester in search order p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  // Next-state logic: arbitration, release, timeout and hold counting.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    take_new  = 1'b0;
    others    = req & ~grant_q;
    win_all   = pick(req, ptr_q);
    win_oth   = pick(others, ptr_q);
    new_win   = win_all;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          take_new = 1'b1;
          new_win  = win_all;
        end
      end
      StOwned: begin
        if (!req[owner_q]) begin
          // Release wins over a coincident timeout, so no preempt here.
          if (|others) begin
            take_new = 1'b1;
            new_win  = win_oth;
          end else begin
            state_d = StIdle;
            grant_d = 4'b0000;
          end
        end else if (cnt_q == CntMax && |others) begin
          take_new  = 1'b1;
          new_win   = win_oth;
          preempt_d = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_new) begin
      state_d = StOwned;
      grant_d = 4'b0001 << new_win;
      owner_d = new_win;
      ptr_d   = new_win + 2'd1;
      cnt_d   = 8'd0;
    end

    busy_d = |grant_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q   <= StIdle;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= 2'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with MAX_HOLD=4.
module tb_bus_arbiter;

  logic       clk;
  logic       reset_;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  int n_checks;
  int n_errors;

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .req     (req),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic p);
    check_eq({tag, ".grant"}, 32'(grant), 32'(g));
    check_eq({tag, ".owner"}, 32'(owner), 32'(o));
    check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    check_eq({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int hold[4];
    bit off[4];
    int idle_cycles;
    logic [3:0] prev_grant;

    n_checks  = 0;
    n_errors  = 0;
    exp_order = '{0, 1, 2, 3, 0};
    reset_    = 1'b0;
    req       = 4'b1111;

    // Reset holds everything low regardless of req.
    tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("reset2", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Basic grant from ptr=0.
    reset_ = 1'b1;
    req    = 4'b1010;
    tick();
    check_out("first_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Release with nobody else waiting: idle, owner held.
    req = 4'b0000;
    tick();
    check_out("release_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    check_out("idle_stay", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Round robin: each master holds 3 cycles, drops for one, re-requests.
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    req    = 4'b1111;
    prev_grant  = 4'b0000;
    idle_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      hold[i] = 0;
      off[i]  = 1'b0;
    end
    for (int c = 0; c < 13; c++) begin
      tick();
      if (grant == 4'b0000) idle_cycles++;
      if (grant != prev_grant && grant != 4'b0000) order.push_back(int'(owner));
      prev_grant = grant;
      for (int i = 0; i < 4; i++) begin
        if (off[i]) begin
          req[i] = 1'b1;
          off[i] = 1'b0;
        end
        if (grant[i]) begin
          hold[i]++;
          if (hold[i] == 3) begin
            req[i]  = 1'b0;
            hold[i] = 0;
            off[i]  = 1'b1;
          end
        end
      end
    end
    check_eq("rr.count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check_eq($sformatf("rr.order%0d", i), 32'(order[i]),
                                     32'(exp_order[i]));
    end
    check_eq("rr.no_idle", 32'(idle_cycles), 32'd0);
    req = 4'b0000;
    tick();
    check_out("rr_drain", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout: master 2 holds 4 cycles, then master 0 forced in.
    req = 4'b0100;
    tick();
    check_out("to_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out($sformatf("to_hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    check_out("to_preempt", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick();
    check_out("to_pulse_end", 4'b0001, 2'd0, 1'b1, 1'b0);
    // Preempted master 2 kept req high and wins back after master 0 times out.
    tick();
    tick();
    check_out("to_back_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_out("to_back", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    check_out("to_drain", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Lone requester never preempted, cnt saturates.
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq($sformatf("lone.grant%0d", c), 32'(grant), 32'(4'b1000));
      check_eq($sformatf("lone.preempt%0d", c), 32'(preempt), 32'd0);
    end
    // Release coinciding with saturated count is a plain release.
    req = 4'b0010;
    tick();
    check_out("sat_release", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset mid-grant drops the grant; arbitration restarts from ptr=0.
    req    = 4'b0011;
    reset_ = 1'b0;
    tick();
    check_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset_ = 1'b1;
    tick();
    check_out("post_reset", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Leave ptr at 3, then reset: 4'b1001 must pick master 0, not 3.
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    check_out("ptr_setup", 4'b0100, 2'd2, 1'b1, 1'b0);
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    req    = 4'b1001;
    tick();
    check_out("ptr_reset", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
